// File: rtl/mc_wbuf_pkg.sv
// mc_wbuf_pkg
//   Shared definitions for the memory-controller write-data buffer.
//   - WBUF_ERR_* : bit positions inside the sticky err vector
//   - WBUF_ERR_W : width of the err vector
//   - ptr_t      : widest slot pointer (DEPTH up to 64); narrower pointers
//                  are zero-extended into it
//   - wbuf_par_ok: even-parity check over {cmd, parity, pointer}
package mc_wbuf_pkg;

  localparam int WBUF_ERR_W         = 5;
  localparam int WBUF_ERR_WR_PERR   = 0;
  localparam int WBUF_ERR_RD_PERR   = 1;
  localparam int WBUF_ERR_MMIO_PERR = 2;
  localparam int WBUF_ERR_RD_EMPTY  = 3;
  localparam int WBUF_ERR_WR_OVW    = 4;

  localparam int WBUF_PTR_MAX_W = 6;
  typedef logic [WBUF_PTR_MAX_W-1:0] ptr_t;

  // Zero-extension of the pointer adds no ones, so the parity result does
  // not depend on the actual pointer width.
  function automatic logic wbuf_par_ok(input logic cmd, input logic par, input ptr_t ptr);
    return ~(^{cmd, par, ptr});
  endfunction

endpackage

// File: rtl/mc_wbuf_dly.sv
// mc_wbuf_dly
//   Valid + data shift pipeline of RD_LAT register stages. Only the valid
//   bits are reset (asynchronously), so a reset discards everything in
//   flight; data stages are plain registers. out_data is forced to 0 while
//   out_vld is low.
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   in_vld, in_data    entry captured at every rising edge
//   out_vld, out_data  entry emerging RD_LAT edges later
module mc_wbuf_dly #(
  parameter int DATA_W = 64,
  parameter int RD_LAT = 3
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_vld,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_vld,
  output logic [DATA_W-1:0] out_data
);

  genvar gi;
  generate
    for (gi = 0; gi < RD_LAT; gi++) begin : stg
      logic              vld_reg;
      logic [DATA_W-1:0] data_reg;
      logic              vld_next;
      logic [DATA_W-1:0] data_next;

      if (gi == 0) begin : g_head
        assign vld_next  = in_vld;
        assign data_next = in_data;
      end else begin : g_body
        assign vld_next  = stg[gi-1].vld_reg;
        assign data_next = stg[gi-1].data_reg;
      end

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) vld_reg <= 1'b0;
        else       vld_reg <= vld_next;
      end

      always_ff @(posedge clk) begin
        data_reg <= data_next;
      end
    end
  endgenerate

  assign out_vld  = stg[RD_LAT-1].vld_reg;
  assign out_data = stg[RD_LAT-1].vld_reg ? stg[RD_LAT-1].data_reg : '0;

endmodule

// File: rtl/mc_wdata_buf.sv
// mc_wdata_buf
//   Write-data buffer between the transaction-layer receiver (writer) and
//   the scheduler (reader), plus a non-releasing MMIO debug read port.
//   DEPTH pointer-addressed slots of DATA_W bits with per-slot occupancy.
//   Scheduler reads release the slot and return data RD_LAT edges later;
//   MMIO reads return data one edge later.
//   Build option: define MC_WBUF_PARITY_EN to check command parity; when
//   undefined the parity inputs are ignored and err[2:0] stay 0.
// Ports:
//   clk, rstn                         clock, asynchronous active-low reset
//   wr, wr_p, wr_ptr, wr_data         write command
//   rd, rd_p, rd_ptr                  scheduler read-and-release command
//   rd_vld, rd_data                   scheduler read result pulse
//   mmio_rd, mmio_rd_p, mmio_ptr      MMIO read command
//   mmio_vld, mmio_data               MMIO read result pulse
//   slot_vld, free_cnt                occupancy map and free slot count
//   err_clr, err                      sticky error bits and their clear
module mc_wdata_buf
  import mc_wbuf_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 8,
  parameter int RD_LAT = 3,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  wr,
  input  logic                  wr_p,
  input  logic [PTR_W-1:0]      wr_ptr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  rd,
  input  logic                  rd_p,
  input  logic [PTR_W-1:0]      rd_ptr,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_vld,
  input  logic                  mmio_rd,
  input  logic                  mmio_rd_p,
  input  logic [PTR_W-1:0]      mmio_ptr,
  output logic [DATA_W-1:0]     mmio_data,
  output logic                  mmio_vld,
  output logic [DEPTH-1:0]      slot_vld,
  output logic [PTR_W:0]        free_cnt,
  input  logic                  err_clr,
  output logic [WBUF_ERR_W-1:0] err
);

  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DEPTH-1:0]      slot_vld_reg, slot_vld_next;
  logic [PTR_W:0]        free_cnt_reg, free_cnt_next;
  logic [WBUF_ERR_W-1:0] err_reg, err_next, err_set;
  logic                  mmio_vld_reg;
  logic [DATA_W-1:0]     mmio_data_reg;

  logic wr_acc, rd_acc, mmio_acc;
  logic wr_perr, rd_perr, mmio_perr;
  logic rd_hit, same_slot;

  // ---------------------------------------------------------------------
  // Command acceptance: a command with bad parity is dropped entirely.
  // ---------------------------------------------------------------------
`ifdef MC_WBUF_PARITY_EN
  assign wr_perr   = wr      & ~wbuf_par_ok(wr,      wr_p,      ptr_t'(wr_ptr));
  assign rd_perr   = rd      & ~wbuf_par_ok(rd,      rd_p,      ptr_t'(rd_ptr));
  assign mmio_perr = mmio_rd & ~wbuf_par_ok(mmio_rd, mmio_rd_p, ptr_t'(mmio_ptr));
`else
  logic unused_par;
  assign unused_par = ^{wr_p, rd_p, mmio_rd_p};
  assign wr_perr    = 1'b0;
  assign rd_perr    = 1'b0;
  assign mmio_perr  = 1'b0;
`endif

  assign wr_acc   = wr      & ~wr_perr;
  assign rd_acc   = rd      & ~rd_perr;
  assign mmio_acc = mmio_rd & ~mmio_perr;

  assign rd_hit    = slot_vld_reg[rd_ptr];
  assign same_slot = rd_acc & (rd_ptr == wr_ptr);

  // ---------------------------------------------------------------------
  // Occupancy: the read releases first, then the write claims, so a
  // same-edge write to the slot being read leaves it valid.
  // ---------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      assign slot_vld_next[gi] = (wr_acc & (wr_ptr == PTR_W'(gi))) |
                                 (slot_vld_reg[gi] & ~(rd_acc & (rd_ptr == PTR_W'(gi))));
    end
  endgenerate

  always_comb begin
    logic [PTR_W:0] used;
    used = '0;
    for (int i = 0; i < DEPTH; i++) begin
      used = used + {{PTR_W{1'b0}}, slot_vld_next[i]};
    end
    free_cnt_next = (PTR_W+1)'(DEPTH) - used;
  end

  // ---------------------------------------------------------------------
  // Sticky errors: a set on the same edge as err_clr survives the clear.
  // An overwrite is only flagged if the slot is still occupied after any
  // same-edge release.
  // ---------------------------------------------------------------------
  always_comb begin
    err_set                     = '0;
    err_set[WBUF_ERR_WR_PERR]   = wr_perr;
    err_set[WBUF_ERR_RD_PERR]   = rd_perr;
    err_set[WBUF_ERR_MMIO_PERR] = mmio_perr;
    err_set[WBUF_ERR_RD_EMPTY]  = rd_acc & ~rd_hit;
    err_set[WBUF_ERR_WR_OVW]    = wr_acc & slot_vld_reg[wr_ptr] & ~same_slot;
    err_next = (err_clr ? '0 : err_reg) | err_set;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      slot_vld_reg <= '0;
      free_cnt_reg <= (PTR_W+1)'(DEPTH);
      err_reg      <= '0;
      mmio_vld_reg <= 1'b0;
    end else begin
      slot_vld_reg <= slot_vld_next;
      free_cnt_reg <= free_cnt_next;
      err_reg      <= err_next;
      mmio_vld_reg <= mmio_acc;
    end
  end

  // ---------------------------------------------------------------------
  // Slot storage and the MMIO registered read (not reset).
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    mmio_data_reg <= mem[mmio_ptr];
  end

  // ---------------------------------------------------------------------
  // Scheduler read path: the first pipeline stage is the registered read.
  // Empty slots enter the pipe as zero data so the pulse still appears.
  // ---------------------------------------------------------------------
  mc_wbuf_dly #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_dly (
    .clk      (clk),
    .rstn     (rstn),
    .in_vld   (rd_acc),
    .in_data  (rd_hit ? mem[rd_ptr] : '0),
    .out_vld  (rd_vld),
    .out_data (rd_data)
  );

  assign slot_vld  = slot_vld_reg;
  assign free_cnt  = free_cnt_reg;
  assign err       = err_reg;
  assign mmio_vld  = mmio_vld_reg;
  assign mmio_data = mmio_vld_reg ? mmio_data_reg : '0;

endmodule

// File: tb/tb_mc_wdata_buf.sv
// tb_mc_wdata_buf
//   Self-checking bench for mc_wdata_buf: directed scenarios followed by
//   random traffic, all compared against a slot-level reference model
//   (arrays of contents/occupancy, sticky error word, queue of pending
//   scheduler results with due edges).
module tb_mc_wdata_buf;

  localparam int DATA_W = 64;
  localparam int DEPTH  = 8;
  localparam int RD_LAT = 3;
  localparam int PTR_W  = 3;
`ifdef MC_WBUF_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rstn;
  logic              wr, wr_p, rd, rd_p, mmio_rd, mmio_rd_p, err_clr;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr, mmio_ptr;
  logic [DATA_W-1:0] wr_data, rd_data, mmio_data;
  logic              rd_vld, mmio_vld;
  logic [DEPTH-1:0]  slot_vld;
  logic [PTR_W:0]    free_cnt;
  logic [4:0]        err;

  mc_wdata_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .RD_LAT (RD_LAT)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .wr        (wr),
    .wr_p      (wr_p),
    .wr_ptr    (wr_ptr),
    .wr_data   (wr_data),
    .rd        (rd),
    .rd_p      (rd_p),
    .rd_ptr    (rd_ptr),
    .rd_data   (rd_data),
    .rd_vld    (rd_vld),
    .mmio_rd   (mmio_rd),
    .mmio_rd_p (mmio_rd_p),
    .mmio_ptr  (mmio_ptr),
    .mmio_data (mmio_data),
    .mmio_vld  (mmio_vld),
    .slot_vld  (slot_vld),
    .free_cnt  (free_cnt),
    .err_clr   (err_clr),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Reference model state
  typedef struct {
    int          due;
    logic [63:0] data;
  } rd_exp_t;

  logic [63:0] m_mem   [DEPTH];
  bit          m_known [DEPTH];
  bit [DEPTH-1:0] m_vld;
  bit [4:0]    m_err;
  rd_exp_t     rq[$];
  int          edge_n;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  function automatic bit good_par(input bit c, input bit p, input bit [2:0] ptr);
    return ($countones({c, p, ptr}) % 2) == 0;
  endfunction

  // Parity bit that makes {cmd, p, ptr} even, optionally corrupted.
  function automatic bit mk_par(input bit c, input bit [2:0] ptr, input bit bad);
    return (($countones({c, ptr}) % 2) == 1) ^ bad;
  endfunction

  task automatic check_reset_values();
    chk("rst_slot_vld",  64'(slot_vld),  64'd0);
    chk("rst_free_cnt",  64'(free_cnt),  64'(DEPTH));
    chk("rst_err",       64'(err),       64'd0);
    chk("rst_rd_vld",    64'(rd_vld),    64'd0);
    chk("rst_rd_data",   rd_data,        64'd0);
    chk("rst_mmio_vld",  64'(mmio_vld),  64'd0);
    chk("rst_mmio_data", mmio_data,      64'd0);
  endtask

  // One clock: drive commands, advance the model across the edge, compare.
  task automatic step(input bit w, input bit [2:0] wa, input logic [63:0] wd, input bit wbad,
                      input bit r, input bit [2:0] ra, input bit rbad,
                      input bit m, input bit [2:0] ma, input bit mbad,
                      input bit clr);
    bit          wok, rok, mok, e_mv, e_mk, e_rv;
    bit [4:0]    set;
    bit [DEPTH-1:0] after;
    logic [63:0] e_md, e_rd;

    wr = w; wr_ptr = wa; wr_data = wd; wr_p = mk_par(w, wa, wbad);
    rd = r; rd_ptr = ra; rd_p = mk_par(r, ra, rbad);
    mmio_rd = m; mmio_ptr = ma; mmio_rd_p = mk_par(m, ma, mbad);
    err_clr = clr;

    wok = w && (!PAR_EN || good_par(w, wr_p, wa));
    rok = r && (!PAR_EN || good_par(r, rd_p, ra));
    mok = m && (!PAR_EN || good_par(m, mmio_rd_p, ma));
    set = '0;
    set[0] = w && !wok;
    set[1] = r && !rok;
    set[2] = m && !mok;

    // Reads observe the slot as it was before this edge.
    if (rok) begin
      rq.push_back('{edge_n + RD_LAT, m_vld[ra] ? m_mem[ra] : 64'd0});
      if (!m_vld[ra]) set[3] = 1'b1;
    end
    e_mv = mok;
    e_mk = m_known[ma];
    e_md = mok ? m_mem[ma] : 64'd0;

    after = m_vld;
    if (rok) after[ra] = 1'b0;
    if (wok) begin
      if (after[wa]) set[4] = 1'b1;
      after[wa]   = 1'b1;
      m_mem[wa]   = wd;
      m_known[wa] = 1'b1;
    end
    m_vld = after;
    m_err = (clr ? 5'd0 : m_err) | set;

    @(posedge clk);
    #1;
    edge_n++;

    e_rv = 1'b0;
    e_rd = 64'd0;
    if (rq.size() > 0 && rq[0].due == edge_n) begin
      e_rv = 1'b1;
      e_rd = rq[0].data;
      void'(rq.pop_front());
    end

    $display("edge %0d wr=%0d@%0d rd=%0d@%0d mmio=%0d@%0d clr=%0d -> rd_vld=%0d rd_data=%h free=%0d err=%b",
             edge_n, wok, wa, rok, ra, mok, ma, clr, rd_vld, rd_data, free_cnt, err);

    chk("slot_vld", 64'(slot_vld), 64'(m_vld));
    chk("free_cnt", 64'(free_cnt), 64'(DEPTH - $countones(m_vld)));
    chk("err",      64'(err),      64'(m_err));
    chk("rd_vld",   64'(rd_vld),   64'(e_rv));
    chk("rd_data",  rd_data,       e_rd);
    chk("mmio_vld", 64'(mmio_vld), 64'(e_mv));
    if (!e_mv || e_mk) chk("mmio_data", mmio_data, e_md);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 64'd0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic model_reset();
    m_vld = '0;
    m_err = '0;
    rq.delete();
  endtask

  initial begin
    rstn = 1'b0;
    wr = 0; wr_p = 0; wr_ptr = 0; wr_data = 0;
    rd = 0; rd_p = 0; rd_ptr = 0;
    mmio_rd = 0; mmio_rd_p = 0; mmio_ptr = 0; err_clr = 0;
    edge_n = 0;
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i] = 64'd0;
      m_known[i] = 1'b0;
    end
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check_reset_values();
    rstn = 1'b1;

    // Write slot 2, read it back and release it.
    step(1, 2, 64'hDEAD_BEEF_0000_0001, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 64'd0, 0, 1, 2, 0, 1, 2, 0, 0);
    idle(RD_LAT + 1);

    // Corrupted write parity on slot 1, then clear errors.
    step(1, 1, 64'h1111_2222_3333_4444, 1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 64'd0, 0, 0, 0, 0, 1, 3, 0, 1);
    idle(1);

    // Read of an empty slot.
    step(0, 0, 64'd0, 0, 1, 5, 0, 0, 0, 0, 1);
    idle(RD_LAT + 1);

    // Same-edge write and read of slot 4.
    step(1, 4, 64'h0000_0000_0000_0A0A, 0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 4, 64'h0000_0000_0000_0B0B, 0, 1, 4, 0, 0, 0, 0, 0);
    idle(RD_LAT + 1);
    step(0, 0, 64'd0, 0, 1, 4, 0, 1, 4, 0, 1);
    idle(RD_LAT + 1);

    // Fill every slot, then drain back to back.
    for (int i = 0; i < DEPTH; i++)
      step(1, 3'(i), {32'hC0DE_0000 + 32'(i), $urandom}, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++)
      step(0, 0, 64'd0, 0, 1, 3'(i), 0, 0, 0, 0, 0);
    idle(RD_LAT + 1);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), {$urandom, $urandom},
           $urandom_range(0, 7) == 0,
           1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom_range(0, 7) == 0,
           1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom_range(0, 7) == 0,
           $urandom_range(0, 7) == 0);
    end
    idle(RD_LAT + 1);

    // Reset one cycle after a read issue: the pulse must never appear.
    step(1, 6, 64'h6666_0000_6666_0000, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 64'd0, 0, 1, 6, 0, 0, 0, 0, 0);
    step(0, 0, 64'd0, 0, 0, 0, 0, 0, 0, 0, 0);
    rstn = 1'b0;
    model_reset();
    #1;
    check_reset_values();
    repeat (2) @(posedge clk);
    #1;
    edge_n += 2;
    check_reset_values();
    rstn = 1'b1;
    idle(RD_LAT + 2);

    // A pending result left in the model means the DUT never produced it.
    chk("rd_queue_drained", 64'(rq.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
